// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types and constants for the Game-of-Life run controller
package life_pkg;

    localparam int GRID_W = 64;
    localparam int ROW_W  = 8;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] LFSR_DEFAULT = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_EXTINCT = 3'd1;
    localparam logic [2:0] ST_STILL   = 3'd2;
    localparam logic [2:0] ST_OSC2    = 3'd3;
    localparam logic [2:0] ST_LIMIT   = 3'd4;

    // Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/life_lfsr8.sv
// rtl/life_lfsr8.sv - 8-bit Fibonacci LFSR with load and enable
module life_lfsr8
    import life_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [7:0] i_seed,
    input  logic       i_en,
    output logic [7:0] o_state
);

    logic [7:0] r_state;

    // Load wins over advance; an all-zero seed would lock up, so it maps to the default.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= LFSR_DEFAULT;
        end else if (i_load) begin
            r_state <= (i_seed == 8'h00) ? LFSR_DEFAULT : i_seed;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - seed/run/pause/terminate controller for the 8x8 Life datapath
module life_sequencer
    import life_pkg::*;
#(
    parameter int MAX_GEN = 255,
    parameter int GEN_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_step,
    input  logic              i_seed_sel,
    input  logic [GRID_W-1:0] i_seed_grid,
    input  logic [ROW_W-1:0]  i_lfsr_seed,
    input  logic [GRID_W-1:0] i_dp_grid,
    output logic [GRID_W-1:0] o_dp_seed,
    output logic              o_dp_load,
    output logic              o_dp_step,
    output logic [GEN_W-1:0]  o_gen_count,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_status
);

    state_t              r_state;
    state_t              w_next_state;
    logic [GRID_W-1:0]   r_dp_seed;
    logic [GRID_W-1:0]   r_hist1;
    logic [GRID_W-1:0]   r_hist2;
    logic [GEN_W-1:0]    r_gen_count;
    logic [2:0]          r_status;
    logic [2:0]          r_seed_cnt;
    logic [7:0]          w_lfsr;
    logic [2:0]          w_term_code;
    logic                w_term;
    logic                w_dp_load;
    logic                w_dp_step;
    logic                w_begin;
    logic                w_lfsr_load;
    logic                w_lfsr_en;
    logic                w_latch_status;

    life_lfsr8 u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_lfsr_load),
        .i_seed  (i_lfsr_seed),
        .i_en    (w_lfsr_en),
        .o_state (w_lfsr)
    );

    // Termination condition on the current grid, highest priority first.
    always_comb begin
        w_term_code = ST_NONE;
        if (i_dp_grid == '0) begin
            w_term_code = ST_EXTINCT;
        end else if ((r_gen_count != '0) && (i_dp_grid == r_hist1)) begin
            w_term_code = ST_STILL;
        end else if ((r_gen_count >= GEN_W'(2)) && (i_dp_grid == r_hist2)) begin
            w_term_code = ST_OSC2;
        end else if (r_gen_count == GEN_W'(MAX_GEN)) begin
            w_term_code = ST_LIMIT;
        end
    end

    assign w_term = (w_term_code != ST_NONE);

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath command decode.
    always_comb begin
        w_next_state   = r_state;
        w_dp_load      = 1'b0;
        w_dp_step      = 1'b0;
        w_begin        = 1'b0;
        w_lfsr_load    = 1'b0;
        w_lfsr_en      = 1'b0;
        w_latch_status = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_begin      = 1'b1;
                    w_lfsr_load  = i_seed_sel;
                    w_next_state = i_seed_sel ? S_SEED : S_LOAD;
                end
            end
            S_SEED: begin
                w_lfsr_en = 1'b1;
                if (r_seed_cnt == 3'd7) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_dp_load    = 1'b1;
                w_next_state = S_RUN;
            end
            S_RUN: begin
                if (w_term) begin
                    w_latch_status = 1'b1;
                    w_next_state   = S_DONE;
                end else if (i_stop) begin
                    w_next_state = S_PAUSE;
                end else begin
                    w_dp_step = 1'b1;
                end
            end
            S_PAUSE: begin
                if ((i_step || i_start) && w_term) begin
                    w_latch_status = 1'b1;
                    w_next_state   = S_DONE;
                end else if (i_step) begin
                    w_dp_step = 1'b1;
                end else if (i_start) begin
                    w_next_state = S_RUN;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Seed assembly, generation history, counter and status latch.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dp_seed   <= '0;
            r_hist1     <= '0;
            r_hist2     <= '0;
            r_gen_count <= '0;
            r_status    <= ST_NONE;
            r_seed_cnt  <= '0;
        end else begin
            if (w_begin) begin
                r_hist1     <= '0;
                r_hist2     <= '0;
                r_gen_count <= '0;
                r_status    <= ST_NONE;
                r_seed_cnt  <= '0;
                if (!i_seed_sel) begin
                    r_dp_seed <= i_seed_grid;
                end
            end
            if (r_state == S_SEED) begin
                r_dp_seed  <= {w_lfsr, r_dp_seed[GRID_W-1:ROW_W]};
                r_seed_cnt <= r_seed_cnt + 3'd1;
            end
            if (w_dp_step) begin
                r_hist2     <= r_hist1;
                r_hist1     <= i_dp_grid;
                r_gen_count <= r_gen_count + GEN_W'(1);
            end
            if (w_latch_status) begin
                r_status <= w_term_code;
            end
        end
    end

    assign o_dp_seed   = r_dp_seed;
    assign o_dp_load   = w_dp_load;
    assign o_dp_step   = w_dp_step;
    assign o_gen_count = r_gen_count;
    assign o_status    = r_status;
    assign o_busy      = (r_state == S_SEED) || (r_state == S_LOAD) ||
                         (r_state == S_RUN)  || (r_state == S_PAUSE);
    assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_life_sequencer.sv
// tb/tb_life_sequencer.sv - randomized self-checking bench for life_sequencer
module tb_life_sequencer;

    localparam int MG0 = 255;
    localparam int MG1 = 4;

    localparam int M_IDLE  = 0;
    localparam int M_SEED  = 1;
    localparam int M_LOAD  = 2;
    localparam int M_RUN   = 3;
    localparam int M_PAUSE = 4;
    localparam int M_DONE  = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, step, seed_sel;
    logic [63:0] seed_grid;
    logic [7:0]  lfsr_seed;

    logic [63:0] dp_grid   [2];
    logic [63:0] dp_seed   [2];
    logic        dp_load   [2];
    logic        dp_step   [2];
    logic        busy      [2];
    logic        done      [2];
    logic [7:0]  gen_count [2];
    logic [2:0]  status    [2];

    int checks = 0;
    int errors = 0;
    int steps0 = 0;
    int steps1 = 0;
    int loads0 = 0;

    // Reference model state, one slot per DUT instance.
    int          m_mode   [2];
    logic [63:0] m_seed   [2];
    logic [7:0]  m_lfsr   [2];
    int          m_scnt   [2];
    int          m_gen    [2];
    logic [2:0]  m_status [2];
    logic [63:0] m_hist   [2][0:299];

    always #5 clk = ~clk;

    life_sequencer #(.MAX_GEN(MG0), .GEN_W(8)) u_dut0 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop), .i_step(step),
        .i_seed_sel(seed_sel), .i_seed_grid(seed_grid), .i_lfsr_seed(lfsr_seed),
        .i_dp_grid(dp_grid[0]), .o_dp_seed(dp_seed[0]), .o_dp_load(dp_load[0]),
        .o_dp_step(dp_step[0]), .o_gen_count(gen_count[0]), .o_busy(busy[0]),
        .o_done(done[0]), .o_status(status[0])
    );

    life_sequencer #(.MAX_GEN(MG1), .GEN_W(8)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop), .i_step(step),
        .i_seed_sel(seed_sel), .i_seed_grid(seed_grid), .i_lfsr_seed(lfsr_seed),
        .i_dp_grid(dp_grid[1]), .o_dp_seed(dp_seed[1]), .o_dp_load(dp_load[1]),
        .o_dp_step(dp_step[1]), .o_gen_count(gen_count[1]), .o_busy(busy[1]),
        .o_done(done[1]), .o_status(status[1])
    );

    // Toroidal 8x8 Life rule: row r is byte r, column c is bit c of that byte.
    function automatic logic [63:0] life(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0)
                            cnt += int'(g[((r + dr + 8) % 8) * 8 + ((c + dc + 8) % 8)]);
                    end
                end
                n[r * 8 + c] = (cnt == 3) || (g[r * 8 + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] m_lfsr_next(input logic [7:0] v);
        logic b;
        b = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], b};
    endfunction

    // Stop reason implied by the generation history of instance k.
    function automatic logic [2:0] m_term(input int k);
        int g;
        logic [63:0] cur;
        g = m_gen[k];
        cur = m_hist[k][g];
        if (cur == 64'd0) return 3'd1;
        if (g >= 1 && cur == m_hist[k][g - 1]) return 3'd2;
        if (g >= 2 && cur == m_hist[k][g - 2]) return 3'd3;
        if (g == ((k == 0) ? MG0 : MG1)) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [2:0] m_term_now(input int k);
        if (m_mode[k] == M_RUN || m_mode[k] == M_PAUSE) return m_term(k);
        return 3'd0;
    endfunction

    task automatic m_advance(input int k);
        m_hist[k][m_gen[k] + 1] = life(m_hist[k][m_gen[k]]);
        m_gen[k]++;
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE; m_seed[k] = '0; m_lfsr[k] = 8'h01;
            m_scnt[k] = 0; m_gen[k] = 0; m_status[k] = 3'd0;
        end
    endtask

    task automatic m_tick();
        logic [2:0] t;
        for (int k = 0; k < 2; k++) begin
            t = m_term_now(k);
            case (m_mode[k])
                M_IDLE, M_DONE: if (start) begin
                    m_status[k] = 3'd0; m_gen[k] = 0;
                    if (seed_sel) begin
                        m_lfsr[k] = (lfsr_seed == 8'h00) ? 8'h01 : lfsr_seed;
                        m_scnt[k] = 0; m_mode[k] = M_SEED;
                    end else begin
                        m_seed[k] = seed_grid; m_mode[k] = M_LOAD;
                    end
                end
                M_SEED: begin
                    m_seed[k] = {m_lfsr[k], m_seed[k][63:8]};
                    m_lfsr[k] = m_lfsr_next(m_lfsr[k]);
                    m_scnt[k]++;
                    if (m_scnt[k] == 8) m_mode[k] = M_LOAD;
                end
                M_LOAD: begin
                    m_hist[k][0] = m_seed[k]; m_gen[k] = 0; m_mode[k] = M_RUN;
                end
                M_RUN: begin
                    if (t != 3'd0) begin m_status[k] = t; m_mode[k] = M_DONE; end
                    else if (stop) m_mode[k] = M_PAUSE;
                    else m_advance(k);
                end
                M_PAUSE: begin
                    if ((step || start) && t != 3'd0) begin m_status[k] = t; m_mode[k] = M_DONE; end
                    else if (step) m_advance(k);
                    else if (start) m_mode[k] = M_RUN;
                end
                default: m_mode[k] = M_IDLE;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath stand-in: loads or advances on the commanded edge.
    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) dp_grid[k] <= '0;
            else if (dp_load[k]) dp_grid[k] <= dp_seed[k];
            else if (dp_step[k]) dp_grid[k] <= life(dp_grid[k]);
        end
    end

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else m_tick();
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        logic [2:0] t;
        logic       e_step;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                t = m_term_now(k);
                e_step = (m_mode[k] == M_RUN && t == 3'd0 && !stop) ||
                         (m_mode[k] == M_PAUSE && step && t == 3'd0);
                chk($sformatf("d%0d_dp_load", k), 64'(dp_load[k]), 64'(m_mode[k] == M_LOAD));
                chk($sformatf("d%0d_dp_step", k), 64'(dp_step[k]), 64'(e_step));
                chk($sformatf("d%0d_busy", k), 64'(busy[k]), 64'(m_mode[k] >= M_SEED && m_mode[k] <= M_PAUSE));
                chk($sformatf("d%0d_done", k), 64'(done[k]), 64'(m_mode[k] == M_DONE));
                chk($sformatf("d%0d_status", k), 64'(status[k]), 64'(m_status[k]));
                chk($sformatf("d%0d_gen", k), 64'(gen_count[k]), 64'(m_gen[k][7:0]));
                chk($sformatf("d%0d_dp_seed", k), dp_seed[k], m_seed[k]);
                if (m_mode[k] >= M_RUN)
                    chk($sformatf("d%0d_dp_grid", k), dp_grid[k], m_hist[k][m_gen[k]]);
            end
            if (dp_step[0]) steps0++;
            if (dp_step[1]) steps1++;
            if (dp_load[0]) loads0++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic sel, input logic [63:0] grid, input logic [7:0] ls);
        steps0 = 0; steps1 = 0; loads0 = 0;
        seed_sel = sel; seed_grid = grid; lfsr_seed = ls;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(done[0] && done[1]) && n < 3000) begin
            tick();
            n++;
        end
        chk("done_within_budget", {62'd0, done[0], done[1]}, 64'd3);
        tick();
    endtask

    task automatic wait_gen0(input int g);
        int n;
        n = 0;
        while (gen_count[0] != 8'(g) && n < 50) begin
            tick();
            n++;
        end
        chk("reach_gen", 64'(gen_count[0]), 64'(g));
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
        seed_sel = 1'b0; seed_grid = '0; lfsr_seed = '0;
        tick(); tick();
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_done", 64'(done[0]), 64'd0);
        chk("rst_status", 64'(status[0]), 64'd0);
        chk("rst_dp_seed", dp_seed[0], 64'd0);
        reset = 1'b0;
        tick();

        go(1'b0, 64'h0000_0000_0038_0000, 8'h00);
        wait_done();
        chk("blink_status", 64'(status[0]), 64'd3);
        chk("blink_gen", 64'(gen_count[0]), 64'd2);
        chk("blink_loads", 64'(loads0), 64'd1);
        chk("blink_model_status", 64'(m_status[0]), 64'd3);

        go(1'b0, 64'h0000_0000_1818_0000, 8'h00);
        wait_done();
        chk("block_status", 64'(status[0]), 64'd2);
        chk("block_gen", 64'(gen_count[0]), 64'd1);

        go(1'b0, 64'h0000_0000_0001_0000, 8'h00);
        wait_done();
        chk("single_status", 64'(status[0]), 64'd1);
        chk("single_gen", 64'(gen_count[0]), 64'd1);

        go(1'b0, 64'h0, 8'h00);
        wait_done();
        chk("empty_status", 64'(status[0]), 64'd1);
        chk("empty_gen", 64'(gen_count[0]), 64'd0);
        chk("empty_steps", 64'(steps0), 64'd0);

        go(1'b0, 64'h0000_0000_0010_0838, 8'h00);
        wait_done();
        chk("limit_status", 64'(status[1]), 64'd4);
        chk("limit_gen", 64'(gen_count[1]), 64'd4);
        chk("limit_steps", 64'(steps1), 64'd4);
        chk("limit255_gen", 64'(gen_count[0]), 64'd255);
        chk("limit255_model_gen", 64'(m_gen[0]), 64'd255);

        go(1'b0, 64'h0000_0000_0010_0838, 8'h00);
        wait_gen0(2);
        stop = 1'b1;
        tick(); tick();
        chk("pause_gen", 64'(gen_count[0]), 64'd2);
        chk("pause_busy", 64'(busy[0]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick(); step = 1'b0; tick();
        end
        chk("step_gen", 64'(gen_count[0]), 64'd5);
        stop = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("resume_gen", 64'(gen_count[0]), 64'd6);
        wait_done();

        go(1'b1, 64'h0, 8'h00);
        n = 0;
        while (!dp_load[0] && n < 20) begin
            tick();
            n++;
        end
        chk("seed_cycles", 64'(n), 64'd8);
        chk("lfsr0_seed", dp_seed[0], 64'h8E47_2311_0804_0201);
        wait_done();

        go(1'b1, 64'h0, 8'h32);
        wait_done();

        for (int r = 0; r < 10; r++) begin
            go(1'($urandom_range(0, 1)), {$urandom & $urandom, $urandom & $urandom},
               8'($urandom));
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 7) == 0) stop = ~stop;
                step = ($urandom_range(0, 5) == 0);
                tick();
            end
            stop = 1'b0; step = 1'b0;
            start = 1'b1; tick(); start = 1'b0;
            wait_done();
        end

        go(1'b0, 64'h0000_0000_0010_0838, 8'h00);
        wait_gen0(3);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy[0]), 64'd0);
        chk("arst_gen", 64'(gen_count[0]), 64'd0);
        chk("arst_step", 64'(dp_step[0]), 64'd0);
        chk("arst_seed", dp_seed[0], 64'd0);
        tick();
        reset = 1'b0;
        tick();
        go(1'b0, 64'h0000_0000_0038_0000, 8'h00);
        chk("reload_gen", 64'(gen_count[0]), 64'd0);
        wait_done();
        chk("reload_status", 64'(status[0]), 64'd3);
        chk("reload_final_gen", 64'(gen_count[0]), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
Run controller for the 8x8 Game-of-Life datapath.
- Loads a seed grid: external word, or 64 bits expanded from an internal LFSR.
- Steps the datapath one generation per clock, with run/pause/single-step control.
- Stops on extinction, still life, period-2 oscillation or a generation limit, and reports which.
- Sits between the top-level control inputs and the datapath; the datapath only loads, steps or holds.

Parameters:
- MAX_GEN, 255, generation limit; RUN terminates when gen_count reaches it.
- GEN_W, 8, gen_count width; must hold MAX_GEN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  pulse: IDLE/DONE -> seed; PAUSE -> RUN.
- stop  in  1  level: RUN -> PAUSE.
- step  in  1  pulse: one generation while in PAUSE.
- seed_sel  in  1  0 = seed_grid, 1 = LFSR expansion.
- seed_grid  in  64  external seed; row r = bits [8r+7:8r].
- lfsr_seed  in  8  LFSR start value.
- dp_grid  in  64  current datapath grid (registered datapath output).
- dp_seed  out  64  grid presented to datapath for loading.
- dp_load  out  1  datapath loads dp_seed on this edge.
- dp_step  out  1  datapath advances one generation on this edge.
- gen_count  out  GEN_W  generations stepped since load.
- busy  out  1  high in SEED, LOAD, RUN, PAUSE.
- done  out  1  high in DONE.
- status  out  3  0 none, 1 extinct, 2 still, 3 osc2, 4 limit.

Behaviour:
- Reset (async) values:
  - FSM = IDLE.
  - All outputs 0, including dp_seed.
  - hist1 = hist2 = 0.
  - LFSR = 8'h01.
- Datapath contract: dp_load and dp_step are never both 1. The datapath is updated on the edge where either is high, and dp_grid shows the result the next cycle.
- States: IDLE, SEED, LOAD, RUN, PAUSE, DONE.
- IDLE/DONE, start=1:
  - seed_sel=0: dp_seed <= seed_grid, go to LOAD.
  - seed_sel=1: LFSR <= lfsr_seed (8'h01 if lfsr_seed==0), go to SEED.
  - In both cases clear status, gen_count, hist1 and hist2.
- SEED, 8 cycles:
  - Each cycle, shift the LFSR byte into dp_seed: dp_seed <= {lfsr, dp_seed[63:8]}.
  - Then advance the LFSR: Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, new bit0 = b7^b5^b4^b3.
  - After the 8th cycle go to LOAD.
- LOAD: dp_load=1 for one cycle, then RUN.
- Termination check (combinational, on dp_grid), priority order:
  - extinct: dp_grid==0 (any gen_count).
  - still: gen_count>=1 and dp_grid==hist1.
  - osc2: gen_count>=2 and dp_grid==hist2.
  - limit: gen_count==MAX_GEN.
- RUN:
  - Termination true: no step; latch status; go to DONE next edge.
  - Otherwise stop=1: no step; go to PAUSE.
  - Otherwise: dp_step=1. On the same edge hist2<=hist1, hist1<=dp_grid, gen_count++.
- PAUSE:
  - Termination checked only when step or start is requested; if true, behave as the RUN termination case.
  - step=1: one dp_step with the same history update; stay in PAUSE.
  - start=1 (and step=0): go to RUN. start has priority over nothing else; step wins if both are high.
- DONE: done=1; status and gen_count hold until the next start.
- stop in IDLE, SEED, LOAD or DONE: ignored. step outside PAUSE: ignored.
- Reset mid-operation: immediate return to reset values; no partial load is observable after reset.
- Steady-state throughput in RUN: one generation per clock.
- Terminating generation count: the condition is seen the cycle after the last step, so status and gen_count = N are valid in DONE.

Decomposition:
- Package life_pkg holds:
  - state enum.
  - status codes: ST_NONE, ST_EXTINCT, ST_STILL, ST_OSC2, ST_LIMIT.
  - GRID_W=64, ROW_W=8.
  - LFSR tap mask 8'hB8 and LFSR_DEFAULT=8'h01.
- One sub-module, life_lfsr8: load/enable/8-bit state; instantiated by life_sequencer.

Test Plan:
- Blinker: seed_sel=0, seed_grid=64'h0000_0000_0038_0000, start -> dp_load for 1 cycle; then DONE, status=3, gen_count=2.
- Still life and extinction:
  - Block 64'h0000_0000_1818_0000 -> status=2, gen_count=1.
  - Single cell 64'h0000_0000_0001_0000 -> status=1, gen_count=1.
  - Empty grid -> status=1, gen_count=0, zero dp_step pulses.
- Limit: MAX_GEN=4, glider 64'h0000_0000_0010_0838 -> status=4, gen_count=4, exactly 4 dp_step pulses.
- Pause and step: assert stop after 2 steps -> PAUSE with gen_count=2; three step pulses -> gen_count=5; start -> RUN resumes. Compare each dp_grid against a golden model.
- LFSR seeding:
  - lfsr_seed=8'h00 -> behaves as 8'h01; dp_seed low byte equals the first LFSR value, high byte equals the 8th; SEED lasts 8 cycles.
  - lfsr_seed=8'h32 -> dp_seed matches the model sequence.
- Reset mid-RUN at gen_count=3 -> all outputs 0 asynchronously, FSM IDLE; a following start reloads cleanly with gen_count=0.
